// File: rtl/axi_read_master.sv
// AXI3 read-channel initiator: validates one user command, issues it on AR,
// and streams the R beats to the user through a 2-entry buffer.
module axi_read_master #(
    parameter int TXID = 4,
    parameter int ADDR = 32,
    parameter int DATA = 32
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [TXID-1:0] cmd_id,
    input  logic [ADDR-1:0] cmd_addr,
    input  logic [3:0]      cmd_len,
    input  logic [2:0]      cmd_size,
    input  logic [1:0]      cmd_burst,
    output logic            cmd_err,
    output logic [TXID-1:0] arid,
    output logic [ADDR-1:0] araddr,
    output logic [3:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic [1:0]      arlock,
    output logic [3:0]      arcache,
    output logic [2:0]      arprot,
    output logic            arvalid,
    input  logic            arready,
    input  logic [TXID-1:0] rid,
    input  logic [DATA-1:0] rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,
    output logic            dout_valid,
    input  logic            dout_ready,
    output logic [DATA-1:0] dout_data,
    output logic [1:0]      dout_resp,
    output logic            dout_last,
    output logic            done,
    output logic            id_err,
    output logic            last_err,
    output logic            resp_err
);

    localparam int         MAX_SIZE   = $clog2(DATA / 8);
    localparam logic [2:0] MAX_SIZE_L = 3'(MAX_SIZE);
    localparam int         EW         = DATA + 3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA
    } state_t;

    state_t          state_q, state_d;
    logic [TXID-1:0] arid_q, arid_d;
    logic [ADDR-1:0] araddr_q, araddr_d;
    logic [3:0]      arlen_q, arlen_d;
    logic [2:0]      arsize_q, arsize_d;
    logic [1:0]      arburst_q, arburst_d;
    logic [3:0]      beat_q, beat_d;
    logic            cmd_err_q, cmd_err_d;
    logic            done_q, done_d;
    logic            id_err_q, id_err_d;
    logic            last_err_q, last_err_d;
    logic            resp_err_q, resp_err_d;

    logic            wptr_q, wptr_d;
    logic            rptr_q, rptr_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [EW-1:0]   mem_q [2];

    logic [ADDR-1:0] align_mask;
    logic            wrap_len_ok;
    logic            cmd_bad;
    logic            fifo_full;
    logic            r_fire;
    logic            pop;
    logic            beat_is_last;
    logic            r_final;

    always_comb begin
        align_mask  = (ADDR'(1) << cmd_size) - ADDR'(1);
        wrap_len_ok = (cmd_len == 4'd1) || (cmd_len == 4'd3) ||
                      (cmd_len == 4'd7) || (cmd_len == 4'd15);
        cmd_bad     = (cmd_burst == 2'b11) || (cmd_size > MAX_SIZE_L) ||
                      ((cmd_burst == 2'b10) &&
                       (!wrap_len_ok || ((cmd_addr & align_mask) != '0)));
    end

    assign cmd_ready    = (state_q == S_IDLE);
    assign arvalid      = (state_q == S_ADDR);
    assign fifo_full    = (cnt_q == 2'd2);
    // rready looks at current occupancy only, so a simultaneous pop does not reopen it
    assign rready       = (state_q == S_DATA) && !fifo_full;
    assign r_fire       = rvalid && rready;
    assign dout_valid   = (cnt_q != 2'd0);
    assign pop          = dout_valid && dout_ready;
    assign beat_is_last = (beat_q == arlen_q);
    assign r_final      = rlast || beat_is_last;

    assign arid     = arid_q;
    assign araddr   = araddr_q;
    assign arlen    = arlen_q;
    assign arsize   = arsize_q;
    assign arburst  = arburst_q;
    assign arlock   = 2'b00;
    assign arcache  = 4'b0000;
    assign arprot   = 3'b000;
    assign cmd_err  = cmd_err_q;
    assign done     = done_q;
    assign id_err   = id_err_q;
    assign last_err = last_err_q;
    assign resp_err = resp_err_q;

    assign {dout_data, dout_resp, dout_last} = mem_q[rptr_q];

    always_comb begin
        state_d    = state_q;
        arid_d     = arid_q;
        araddr_d   = araddr_q;
        arlen_d    = arlen_q;
        arsize_d   = arsize_q;
        arburst_d  = arburst_q;
        beat_d     = beat_q;
        cmd_err_d  = 1'b0;
        done_d     = 1'b0;
        id_err_d   = id_err_q;
        last_err_d = last_err_q;
        resp_err_d = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        cmd_err_d = 1'b1;
                    end else begin
                        arid_d     = cmd_id;
                        araddr_d   = cmd_addr;
                        arlen_d    = cmd_len;
                        arsize_d   = cmd_size;
                        arburst_d  = cmd_burst;
                        id_err_d   = 1'b0;
                        last_err_d = 1'b0;
                        resp_err_d = 1'b0;
                        state_d    = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (arready) begin
                    beat_d  = 4'd0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (r_fire) begin
                    beat_d = beat_q + 4'd1;
                    if (rid != arid_q)         id_err_d   = 1'b1;
                    if (rlast != beat_is_last) last_err_d = 1'b1;
                    if (rresp != 2'b00)        resp_err_d = 1'b1;
                    if (r_final) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wptr_d = wptr_q ^ r_fire;
        rptr_d = rptr_q ^ pop;
        case ({r_fire, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= S_IDLE;
            arid_q     <= '0;
            araddr_q   <= '0;
            arlen_q    <= '0;
            arsize_q   <= '0;
            arburst_q  <= '0;
            beat_q     <= '0;
            cmd_err_q  <= 1'b0;
            done_q     <= 1'b0;
            id_err_q   <= 1'b0;
            last_err_q <= 1'b0;
            resp_err_q <= 1'b0;
            wptr_q     <= 1'b0;
            rptr_q     <= 1'b0;
            cnt_q      <= 2'd0;
        end else begin
            state_q    <= state_d;
            arid_q     <= arid_d;
            araddr_q   <= araddr_d;
            arlen_q    <= arlen_d;
            arsize_q   <= arsize_d;
            arburst_q  <= arburst_d;
            beat_q     <= beat_d;
            cmd_err_q  <= cmd_err_d;
            done_q     <= done_d;
            id_err_q   <= id_err_d;
            last_err_q <= last_err_d;
            resp_err_q <= resp_err_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
        end
    end

    // Buffer storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge aclk) begin
        if (r_fire) begin
            mem_q[wptr_q] <= {rdata, rresp, r_final};
        end
    end

endmodule

// File: tb/tb_axi_read_master.sv
// Bench for axi_read_master: vector table of commands plus hand-written
// sequences; delivered beats are checked against a scoreboard queue.
module tb_axi_read_master;

    localparam int TXID = 4;
    localparam int ADDR = 32;
    localparam int DATA = 32;

    logic            aclk = 1'b0;
    logic            areset;
    logic            cmd_valid, cmd_ready;
    logic [TXID-1:0] cmd_id;
    logic [ADDR-1:0] cmd_addr;
    logic [3:0]      cmd_len;
    logic [2:0]      cmd_size;
    logic [1:0]      cmd_burst;
    logic            cmd_err;
    logic [TXID-1:0] arid;
    logic [ADDR-1:0] araddr;
    logic [3:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [1:0]      arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic            arvalid, arready;
    logic [TXID-1:0] rid;
    logic [DATA-1:0] rdata;
    logic [1:0]      rresp;
    logic            rlast, rvalid, rready;
    logic            dout_valid, dout_ready;
    logic [DATA-1:0] dout_data;
    logic [1:0]      dout_resp;
    logic            dout_last;
    logic            done, id_err, last_err, resp_err;

    always #5 aclk = ~aclk;

    axi_read_master #(.TXID(TXID), .ADDR(ADDR), .DATA(DATA)) dut (
        .aclk(aclk), .areset(areset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_id(cmd_id),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
        .cmd_burst(cmd_burst), .cmd_err(cmd_err),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
        .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
        .rvalid(rvalid), .rready(rready),
        .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dout_data(dout_data), .dout_resp(dout_resp), .dout_last(dout_last),
        .done(done), .id_err(id_err), .last_err(last_err), .resp_err(resp_err)
    );

    typedef struct packed {
        logic [DATA-1:0] d;
        logic [1:0]      r;
        logic            l;
    } beat_t;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
        logic        rej;
        int          fault;   // 0 none, 1 early rlast, 2 SLVERR resp, 3 wrong rid
        int          fbeat;
        logic        e_last;
        logic        e_resp;
        logic        e_id;
    } vec_t;

    beat_t sb[$];
    vec_t  tbl[11];
    int    total = 0;
    int    bad = 0;
    int    done_cnt = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    always @(negedge aclk) begin : mon
        beat_t e;
        if (done === 1'b1) done_cnt++;
        if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL dout_unexpected got=%0h want=none", dout_data);
            end else begin
                e = sb.pop_front();
                check("dout_data", 64'(dout_data), 64'(e.d));
                check("dout_resp", 64'(dout_resp), 64'(e.r));
                check("dout_last", 64'(dout_last), 64'(e.l));
            end
        end
    end

    task automatic send_cmd(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                            input logic [2:0] size, input logic [1:0] burst);
        bit ok;
        cmd_id = id; cmd_addr = addr; cmd_len = len; cmd_size = size; cmd_burst = burst;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge aclk);
            if (cmd_ready) begin ok = 1'b1; break; end
        end
        if (!ok) check("cmd_ready_timeout", 64'(0), 64'(1));
        @(posedge aclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic r_beat(input logic [3:0] id, input logic [31:0] d, input logic [1:0] resp,
                          input logic last);
        bit ok;
        rid = id; rdata = d; rresp = resp; rlast = last; rvalid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            @(negedge aclk);
            if (rready) begin ok = 1'b1; break; end
        end
        if (!ok) check("rready_timeout", 64'(0), 64'(1));
        @(posedge aclk); #1;
        rvalid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 60 && sb.size() != 0; k++) @(negedge aclk);
        repeat (2) @(posedge aclk);
        #1;
        check("sb_empty", 64'(sb.size()), 64'(0));
    endtask

    task automatic run_vec(input vec_t v, input int t);
        int          d0;
        logic [3:0]  rid_v;
        logic [1:0]  rr;
        logic        rl, fin;
        logic [31:0] dv;
        d0 = done_cnt;
        send_cmd(v.id, v.addr, v.len, v.size, v.burst);
        @(negedge aclk);
        if (v.rej) begin
            check("cmd_err", 64'(cmd_err), 64'(1));
            check("rej_arvalid", 64'(arvalid), 64'(0));
            @(negedge aclk);
            check("cmd_err_pulse", 64'(cmd_err), 64'(0));
            check("rej_arvalid2", 64'(arvalid), 64'(0));
            check("rej_idle", 64'(cmd_ready), 64'(1));
            @(posedge aclk); #1;
        end else begin
            check("arvalid", 64'(arvalid), 64'(1));
            check("araddr", 64'(araddr), 64'(v.addr));
            check("arlen", 64'(arlen), 64'(v.len));
            check("arid", 64'(arid), 64'(v.id));
            check("arburst", 64'(arburst), 64'(v.burst));
            check("flags_clear", 64'({id_err, last_err, resp_err}), 64'(0));
            check("cmd_err_acc", 64'(cmd_err), 64'(0));
            @(posedge aclk); #1;
            for (int i = 0; i <= int'(v.len); i++) begin
                rid_v = (v.fault == 3) ? 4'd6 : v.id;
                rr    = (v.fault == 2 && i == v.fbeat) ? 2'd2 : 2'd0;
                rl    = (v.fault == 1) ? (i == v.fbeat) : (i == int'(v.len));
                fin   = rl || (i == int'(v.len));
                dv    = 32'(32'hA000_0000 + (t << 8) + i);
                sb.push_back('{d: dv, r: rr, l: fin});
                r_beat(rid_v, dv, rr, rl);
                if (fin) break;
            end
            drain();
            check("done_once", 64'(done_cnt - d0), 64'(1));
            check("last_err", 64'(last_err), 64'(v.e_last));
            check("resp_err", 64'(resp_err), 64'(v.e_resp));
            check("id_err", 64'(id_err), 64'(v.e_id));
            check("back_idle", 64'(cmd_ready), 64'(1));
        end
    endtask

    initial begin
        int          d0;
        logic [31:0] dv;
        tbl[0]  = '{4'd5, 32'h100, 4'd3, 3'd2, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{4'd5, 32'h100, 4'd2, 3'd2, 2'b10, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[2]  = '{4'd5, 32'h102, 4'd3, 3'd2, 2'b10, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[3]  = '{4'd2, 32'h100, 4'd7, 3'd2, 2'b10, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[4]  = '{4'd1, 32'h000, 4'd0, 3'd0, 2'b11, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[5]  = '{4'd1, 32'h000, 4'd0, 3'd3, 2'b01, 1'b1, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[6]  = '{4'd5, 32'h200, 4'd3, 3'd2, 2'b01, 1'b0, 1, 1, 1'b1, 1'b0, 1'b0};
        tbl[7]  = '{4'd5, 32'h300, 4'd3, 3'd2, 2'b01, 1'b0, 2, 0, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{4'd5, 32'h400, 4'd3, 3'd2, 2'b01, 1'b0, 3, 0, 1'b0, 1'b0, 1'b1};
        tbl[9]  = '{4'd9, 32'h003, 4'd0, 3'd0, 2'b00, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{4'd3, 32'h500, 4'd3, 3'd2, 2'b01, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0};

        areset = 1'b1; cmd_valid = 1'b0; cmd_id = '0; cmd_addr = '0; cmd_len = '0;
        cmd_size = '0; cmd_burst = '0; arready = 1'b1; rid = '0; rdata = '0;
        rresp = '0; rlast = 1'b0; rvalid = 1'b0; dout_ready = 1'b1;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        check("rst_arvalid", 64'(arvalid), 64'(0));
        check("rst_rready", 64'(rready), 64'(0));
        check("rst_dout_valid", 64'(dout_valid), 64'(0));
        check("rst_cmd_ready", 64'(cmd_ready), 64'(1));
        check("rst_pulses", 64'({cmd_err, done}), 64'(0));
        check("rst_flags", 64'({id_err, last_err, resp_err}), 64'(0));
        check("rst_araddr", 64'(araddr), 64'(0));
        @(posedge aclk); #1;
        areset = 1'b0;

        for (int n = 0; n < 11; n++) run_vec(tbl[n], n);

        // backpressure: user stalls, buffer fills after two beats
        dout_ready = 1'b0;
        send_cmd(4'd7, 32'h800, 4'd7, 3'd2, 2'b01);
        @(posedge aclk); #1;
        for (int i = 0; i < 8; i++) begin
            dv = 32'hB000_0000 + 32'(i);
            sb.push_back('{d: dv, r: 2'd0, l: (i == 7)});
            r_beat(4'd7, dv, 2'd0, i == 7);
            if (i == 1) begin
                rvalid = 1'b1; rdata = 32'hB000_0002; rlast = 1'b0;
                repeat (3) begin
                    @(negedge aclk);
                    check("bp_rready_low", 64'(rready), 64'(0));
                end
                check("bp_dout_valid", 64'(dout_valid), 64'(1));
                @(posedge aclk); #1;
                dout_ready = 1'b1;
            end
        end
        drain();

        // AR stall: arready low for five cycles
        arready = 1'b0;
        d0 = done_cnt;
        send_cmd(4'd4, 32'h940, 4'd1, 3'd2, 2'b01);
        for (int k = 0; k < 5; k++) begin
            @(negedge aclk);
            check("stall_arvalid", 64'(arvalid), 64'(1));
            check("stall_araddr", 64'(araddr), 64'(32'h940));
            check("stall_arlen", 64'(arlen), 64'(1));
            @(posedge aclk); #1;
        end
        arready = 1'b1;
        @(negedge aclk);
        check("stall_arvalid6", 64'(arvalid), 64'(1));
        @(posedge aclk); #1;
        arready = 1'b0;
        @(negedge aclk);
        check("stall_arvalid_drop", 64'(arvalid), 64'(0));
        @(posedge aclk); #1;
        arready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dv = 32'hC000_0000 + 32'(i);
            sb.push_back('{d: dv, r: 2'd0, l: (i == 1)});
            r_beat(4'd4, dv, 2'd0, i == 1);
        end
        drain();
        check("stall_done", 64'(done_cnt - d0), 64'(1));

        // reset in the middle of the data phase
        d0 = done_cnt;
        send_cmd(4'd5, 32'hA00, 4'd3, 3'd2, 2'b01);
        @(posedge aclk); #1;
        for (int i = 0; i < 2; i++) begin
            dv = 32'hD000_0000 + 32'(i);
            sb.push_back('{d: dv, r: 2'd0, l: 1'b0});
            r_beat(4'd6, dv, 2'd0, 1'b0);
        end
        @(negedge aclk);
        check("mid_id_err", 64'(id_err), 64'(1));
        @(posedge aclk); #1;
        areset = 1'b1;
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check("mr_arvalid", 64'(arvalid), 64'(0));
        check("mr_rready", 64'(rready), 64'(0));
        check("mr_dout_valid", 64'(dout_valid), 64'(0));
        check("mr_flags", 64'({id_err, last_err, resp_err}), 64'(0));
        check("mr_cmd_ready", 64'(cmd_ready), 64'(1));
        repeat (4) @(posedge aclk);
        #1;
        check("mr_no_done", 64'(done_cnt - d0), 64'(0));
        check("mr_sb_empty", 64'(sb.size()), 64'(0));

        run_vec(tbl[0], 20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1);
    end

endmodule

// File: doc/axi_read_master.md
Name: axi_read_master

Overview:
- AXI3 read-channel initiator. Accepts one read command from a local user, checks it for legality, and drives the AR channel.
- Collects the R beats into a 2-entry buffer and streams them to the user.
- Flags protocol and response errors seen from the slave.
- Single outstanding transaction; it pairs with the slave-side read responder in the same verification environment.

Parameters:
- TXID, 4, ID width.
- ADDR, 32, address width.
- DATA, 32, data width; DATA/8 bytes per beat, so max legal size = log2(DATA/8).

Ports:
- aclk  in  1  clock
- areset  in  1  synchronous reset, active-high
- cmd_valid  in  1  user command valid
- cmd_ready  out  1  block can accept a command
- cmd_id  in  TXID  transaction ID
- cmd_addr  in  ADDR  start address
- cmd_len  in  4  beats-1
- cmd_size  in  3  log2 bytes per beat
- cmd_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
- cmd_err  out  1  1-cycle pulse: command rejected
- arid/araddr/arlen/arsize/arburst  out  TXID/ADDR/4/3/2  AR payload
- arlock/arcache/arprot  out  2/4/3  tied 0
- arvalid  out  1
- arready  in  1
- rid  in  TXID
- rdata  in  DATA
- rresp  in  2
- rlast  in  1
- rvalid  in  1
- rready  out  1
- dout_valid/dout_ready  out/in  1  user data handshake
- dout_data  out  DATA
- dout_resp  out  2
- dout_last  out  1  final beat of the transaction
- done  out  1  1-cycle pulse on completion
- id_err/last_err/resp_err  out  1 each  sticky status

Behaviour:
- Reset (areset high at a posedge aclk):
  - State returns to IDLE; FIFO is flushed.
  - arvalid=0, rready=0, cmd_err=0, done=0, dout_valid=0, all error flags=0, AR payload=0.
  - Reset mid-transaction abandons it; no done pulse is produced.
- cmd_ready=1 only in IDLE.
- A command is accepted on cmd_valid && cmd_ready.
- A command is rejected (cmd_err pulses the next cycle, state stays IDLE, no AR) when any of these holds:
  - cmd_burst==11;
  - cmd_size > log2(DATA/8);
  - WRAP with cmd_len+1 not in {2,4,8,16};
  - WRAP with cmd_addr not aligned to 2**cmd_size.
- INCR and FIXED are accepted at any alignment.
- On acceptance of a legal command:
  - Clear the three sticky error flags.
  - Register the payload into the AR outputs and latch id and len.
  - Move to ADDR.
- ADDR:
  - arvalid=1 from the cycle after acceptance.
  - Payload is held stable until arready is sampled high.
  - arvalid drops in the cycle after the handshake; state moves to DATA and the beat counter clears to 0.
- DATA:
  - rready = FIFO not full (depth 2).
  - On each rvalid && rready, push {rdata, rresp, final} into the FIFO and increment the beat counter.
  - final = rlast || (beat counter == latched len).
  - last_err is set if rlast != (beat counter == latched len).
  - id_err is set if rid != latched id.
  - resp_err is set if rresp != 00; the data is still forwarded with its resp.
  - On a final beat, rready drops the next cycle, the state returns to IDLE, and done pulses the cycle after the final beat is accepted.
  - Any R beats arriving outside DATA are not accepted (rready=0).
- FIFO:
  - dout_valid = FIFO not empty; dout_* show the head entry.
  - A pop occurs on dout_valid && dout_ready.
  - Push and pop in the same cycle keep the occupancy unchanged.
  - A full FIFO deasserts rready combinationally from the current occupancy.
  - Beat order is preserved.
- A new command may be accepted in IDLE while the FIFO still holds the previous transaction's beats; FIFO order keeps the beats separated, and dout_last marks the boundary.

Test Plan:
1. INCR: id=5, addr=0x100, len=3, size=2; arready=1, 4 R beats with rlast on the 4th, dout_ready=1 -> arvalid asserted 1 cycle after acceptance with araddr=0x100, arlen=3; 4 dout beats in order, dout_last on the 4th; done pulses once; no error flags.
2. WRAP len=2 (3 beats) -> cmd_err pulse, arvalid stays 0; WRAP addr=0x102, size=2 -> cmd_err; WRAP addr=0x100, len=7, size=2 -> accepted.
3. Backpressure: INCR len=7 with dout_ready=0 -> rready drops after 2 beats are accepted; release dout_ready -> all 8 beats are delivered in order, none lost or duplicated.
4. Slave faults, each in a separate transaction, len=3:
   - rlast on beat 2 -> last_err=1, dout_last on beat 2, return to IDLE.
   - rresp=2 on beat 1 -> resp_err=1, dout_resp=2.
   - rid=6 vs id=5 -> id_err=1.
   - Flags clear on the next accepted command.
5. arready held low 5 cycles -> arvalid and payload stable throughout; the handshake happens on cycle 6.
6. areset asserted mid-DATA after 2 of 4 beats -> next cycle: arvalid=0, rready=0, dout_valid=0, error flags=0, cmd_ready=1; no done pulse.
